writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 138 +++++++++++++
 tb/tb_writeback_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: serialises ALU and load results into a single register-file
// write port. Requests are queued in FIFO order, and loads win arbitration.
// Writes to r0 complete the handshake but are dropped. QueryPending reports
// whether a write to a queried register is still outstanding, either queued or
// presented on the write port this cycle.
module writeback_unit #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     AluValid,
  input  logic [4:0]               AluReg,
  input  logic [31:0]              AluData,
  output logic                     AluReady,
  input  logic                     MemValid,
  input  logic [4:0]               MemReg,
  input  logic [31:0]              MemData,
  output logic                     MemReady,
  output logic [4:0]               WriteReg,
  output logic [31:0]              WriteData,
  output logic                     RegWrite,
  input  logic [4:0]               QueryReg,
  output logic                     QueryPending,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [4:0]  ent_reg_q  [DEPTH];
  logic [4:0]  ent_reg_d  [DEPTH];
  logic [31:0] ent_data_q [DEPTH];
  logic [31:0] ent_data_d [DEPTH];
  logic [4:0]  write_reg_q, write_reg_d;
  logic [31:0] write_data_q, write_data_d;
  logic        reg_write_q, reg_write_d;

  logic        not_full;
  logic        mem_fire, alu_fire;
  logic        push, pop;
  logic [4:0]  push_reg;
  logic [31:0] push_data;
  logic        query_hit;

  // Handshake and arbitration: loads take priority, and at most one push per cycle.
  always_comb begin
    not_full  = (count_q != FULL_CNT);
    MemReady  = rst_n && not_full;
    AluReady  = rst_n && not_full && !MemValid;
    mem_fire  = MemValid && MemReady;
    alu_fire  = AluValid && AluReady;
    push_reg  = mem_fire ? MemReg : AluReg;
    push_data = mem_fire ? MemData : AluData;
    // r0 requests are acknowledged but never stored
    push      = (mem_fire || alu_fire) && (push_reg != 5'd0);
    pop       = (count_q != '0);
  end

  // Next-state for queue storage, pointers, occupancy and the write port.
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    count_d      = count_q;
    vld_d        = vld_q;
    ent_reg_d    = ent_reg_q;
    ent_data_d   = ent_data_q;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    reg_write_d  = 1'b0;
    if (pop) begin
      write_reg_d   = ent_reg_q[rptr_q];
      write_data_d  = ent_data_q[rptr_q];
      reg_write_d   = 1'b1;
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + 1'b1;
    end
    // A push never targets the slot being popped: pushing needs a non-full queue
    if (push) begin
      ent_reg_d[wptr_q]  = push_reg;
      ent_data_d[wptr_q] = push_data;
      vld_d[wptr_q]      = 1'b1;
      wptr_d             = wptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Hazard lookup over valid queue entries and the write currently on the port.
  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (ent_reg_q[i] == QueryReg)) query_hit = 1'b1;
    end
    if (reg_write_q && (write_reg_q == QueryReg)) query_hit = 1'b1;
    QueryPending = rst_n && (QueryReg != 5'd0) && query_hit;
  end

  // Control state and write-port registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      vld_q        <= '0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      reg_write_q  <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      vld_q        <= vld_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      reg_write_q  <= reg_write_d;
    end
  end

  // Queue payload storage; contents are qualified by vld_q, so no reset is needed.
  always_ff @(posedge clk) begin
    ent_reg_q  <= ent_reg_d;
    ent_data_q <= ent_data_d;
  end

  assign WriteReg  = write_reg_q;
  assign WriteData = write_data_q;
  assign RegWrite  = reg_write_q;
  assign Count     = count_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit. The reference model is a queue of pending
// writes plus the last issued write; outputs are compared after every edge.
module tb_writeback_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        AluValid, MemValid;
  logic [4:0]  AluReg, MemReg, QueryReg;
  logic [31:0] AluData, MemData;
  logic        AluReady, MemReady;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic        QueryPending;
  logic [2:0]  Count;

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData), .AluReady(AluReady),
    .MemValid(MemValid), .MemReg(MemReg), .MemData(MemData), .MemReady(MemReady),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .QueryReg(QueryReg), .QueryPending(QueryPending), .Count(Count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [4:0] r; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic        m_rw;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;

  // observed (s_) and expected (e_) combinational outputs just before the edge
  logic s_aready, s_mready, s_qp;
  logic e_aready, e_mready, e_qp;

  // Drives one cycle of stimulus, samples the combinational outputs before the
  // edge, and advances the reference model across the edge.
  task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic [4:0] qr, input logic rn);
    logic hit;
    logic acc;
    ent_t e;
    AluValid = av; AluReg = ar; AluData = ad;
    MemValid = mv; MemReg = mr; MemData = md;
    QueryReg = qr; rst_n = rn;
    #1;
    s_aready = AluReady; s_mready = MemReady; s_qp = QueryPending;
    e_mready = rn && (mq.size() < DEPTH);
    e_aready = e_mready && !mv;
    hit = m_rw && (m_wreg == qr);
    foreach (mq[i]) if (mq[i].r == qr) hit = 1'b1;
    e_qp = rn && (qr != 5'd0) && hit;
    @(posedge clk);
    if (!rn) begin
      mq.delete();
      m_rw = 1'b0; m_wreg = '0; m_wdata = '0;
    end else begin
      acc = 1'b0;
      if (mv && e_mready) begin e.r = mr; e.d = md; acc = 1'b1; end
      else if (av && e_aready) begin e.r = ar; e.d = ad; acc = 1'b1; end
      if (mq.size() > 0) begin
        m_rw = 1'b1; m_wreg = mq[0].r; m_wdata = mq[0].d;
        void'(mq.pop_front());
      end else begin
        m_rw = 1'b0;
      end
      if (acc && e.r != 5'd0) mq.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] qr);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qr, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 5'd9, $urandom, 1'b1, 5'd10, $urandom, 5'd9, 1'b0);
      checks++;
      if (s_aready !== 1'b0 || s_mready !== 1'b0 || s_qp !== 1'b0) begin
        errors++;
        $display("FAIL reset_comb: ready alu=%b mem=%b qp=%b, required 0 0 0", s_aready, s_mready, s_qp);
      end
      checks++;
      if (RegWrite !== 1'b0 || Count !== 3'd0 || WriteReg !== 5'd0 || WriteData !== 32'd0) begin
        errors++;
        $display("FAIL reset_state: rw=%b cnt=%0d wreg=%0d wdata=%h, required 0 0 0 0", RegWrite, Count, WriteReg, WriteData);
      end
    end
  endtask

  task automatic test_single_alu();
    cycle(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd0, 32'd0, 5'd0, 1'b1);
    checks++;
    if (s_aready !== 1'b1 || RegWrite !== 1'b0 || Count !== 3'd1) begin
      errors++;
      $display("FAIL single_push: aready=%b rw=%b cnt=%0d, required 1 0 1", s_aready, RegWrite, Count);
    end
    idle(5'd0);
    checks++;
    if (RegWrite !== 1'b1 || WriteReg !== 5'd5 || WriteData !== 32'hAA || Count !== 3'd0) begin
      errors++;
      $display("FAIL single_issue: rw=%b wreg=%0d wdata=%h cnt=%0d, required 1 5 000000aa 0", RegWrite, WriteReg, WriteData, Count);
    end
    idle(5'd0);
    checks++;
    if (RegWrite !== 1'b0 || WriteReg !== 5'd5 || WriteData !== 32'hAA) begin
      errors++;
      $display("FAIL single_after: rw=%b wreg=%0d wdata=%h, required 0 5 000000aa (held)", RegWrite, WriteReg, WriteData);
    end
  endtask

  task automatic test_priority();
    cycle(1'b1, 5'd3, 32'h3333, 1'b1, 5'd4, 32'h4444, 5'd0, 1'b1);
    checks++;
    if (s_mready !== 1'b1 || s_aready !== 1'b0) begin
      errors++;
      $display("FAIL prio_ready: mready=%b aready=%b, required 1 0", s_mready, s_aready);
    end
    cycle(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'd0, 5'd0, 1'b1);
    checks++;
    if (s_aready !== 1'b1 || RegWrite !== 1'b1 || WriteReg !== 5'd4 || WriteData !== 32'h4444) begin
      errors++;
      $display("FAIL prio_first: aready=%b rw=%b wreg=%0d wdata=%h, required 1 1 4 00004444", s_aready, RegWrite, WriteReg, WriteData);
    end
    idle(5'd0);
    checks++;
    if (RegWrite !== 1'b1 || WriteReg !== 5'd3 || WriteData !== 32'h3333) begin
      errors++;
      $display("FAIL prio_second: rw=%b wreg=%0d wdata=%h, required 1 3 00003333", RegWrite, WriteReg, WriteData);
    end
    idle(5'd0);
  endtask

  task automatic test_zero_reg();
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 1'b1);
    checks++;
    if (s_mready !== 1'b1 || s_qp !== 1'b0 || Count !== 3'd0) begin
      errors++;
      $display("FAIL zero_push: mready=%b qp=%b cnt=%0d, required 1 0 0", s_mready, s_qp, Count);
    end
    idle(5'd0);
    checks++;
    if (RegWrite !== 1'b0 || s_qp !== 1'b0 || Count !== 3'd0) begin
      errors++;
      $display("FAIL zero_nowrite: rw=%b qp=%b cnt=%0d, required 0 0 0", RegWrite, s_qp, Count);
    end
  endtask

  task automatic test_hazard();
    // expected QueryPending just before each edge: empty, queued, on port, done
    logic [3:0] exp_qp = 4'b0110;
    cycle(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 5'd7, 1'b1);
    checks++;
    if (s_qp !== exp_qp[0]) begin
      errors++;
      $display("FAIL hazard_0: qp=%b, required %b", s_qp, exp_qp[0]);
    end
    for (int i = 1; i < 4; i++) begin
      idle(5'd7);
      checks++;
      if (s_qp !== exp_qp[i]) begin
        errors++;
        $display("FAIL hazard_%0d: qp=%b, required %b", i, s_qp, exp_qp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 5'($urandom_range(31, 1)), $urandom, 1'b1, 5'($urandom_range(31, 1)), $urandom,
            5'($urandom_range(31, 0)), 1'b1);
      checks++;
      if (s_aready !== e_aready || s_mready !== e_mready || s_qp !== e_qp) begin
        errors++;
        $display("FAIL b2b_comb: aready=%b mready=%b qp=%b, required %b %b %b", s_aready, s_mready, s_qp, e_aready, e_mready, e_qp);
      end
      checks++;
      if (RegWrite !== m_rw || Count !== 3'(mq.size()) || Count > 3'(DEPTH) ||
          (m_rw && (WriteReg !== m_wreg || WriteData !== m_wdata))) begin
        errors++;
        $display("FAIL b2b_out: rw=%b wreg=%0d wdata=%h cnt=%0d, required %b %0d %h %0d", RegWrite, WriteReg, WriteData, Count, m_rw, m_wreg, m_wdata, mq.size());
      end
    end
    idle(5'd0);
    idle(5'd0);
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 5'd12, 32'hC0C0, 1'b0, 5'd0, 32'd0, 5'd0, 1'b1);
    cycle(1'b1, 5'd13, 32'hD0D0, 1'b1, 5'd0, 32'd0, 5'd0, 1'b0);
    checks++;
    if (Count !== 3'd0 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: cnt=%0d rw=%b, required 0 0", Count, RegWrite);
    end
    for (int i = 0; i < 3; i++) begin
      idle(5'd12);
      checks++;
      if (RegWrite !== 1'b0 || s_qp !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_after_%0d: rw=%b qp=%b, required 0 0", i, RegWrite, s_qp);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), $urandom,
            1'($urandom_range(3, 0) == 0), 5'($urandom_range(31, 0)), $urandom,
            5'($urandom_range(31, 0)), ($urandom_range(49, 0) != 0));
      checks++;
      if (s_aready !== e_aready || s_mready !== e_mready || s_qp !== e_qp) begin
        errors++;
        $display("FAIL rand_comb[%0d]: aready=%b mready=%b qp=%b, required %b %b %b", i, s_aready, s_mready, s_qp, e_aready, e_mready, e_qp);
      end
      checks++;
      if (RegWrite !== m_rw || Count !== 3'(mq.size()) || WriteReg !== m_wreg || WriteData !== m_wdata) begin
        errors++;
        $display("FAIL rand_out[%0d]: rw=%b wreg=%0d wdata=%h cnt=%0d, required %b %0d %h %0d", i, RegWrite, WriteReg, WriteData, Count, m_rw, m_wreg, m_wdata, mq.size());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    AluValid = 1'b0; AluReg = '0; AluData = '0;
    MemValid = 1'b0; MemReg = '0; MemData = '0;
    QueryReg = '0;
    m_rw = 1'b0; m_wreg = '0; m_wdata = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_alu();
    test_priority();
    test_zero_reg();
    test_hazard();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
